uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single uart transmitter among NREQ requesters (e.g. echo path, status reporter, switch-triggered sender).
//  Round-robin arbitration with packet lock: a granted requester keeps the TX until it sends a byte flagged last or hits MAX_BURST.
//  Sequences the uart handshake: one-cycle transmit pulse per byte, then waits for is_transmitting to rise and fall before the next byte.
//  Never re-issues a byte while the uart is busy.
// PARAMETERS
//  NREQ       4    number of requesters (2..8)
//  MAX_BURST  16   max bytes per grant before forced rotation (1..255)
//  BUSY_TO    15   cycles to wait for tx_busy to rise after a pulse before flagging an error (1..255)
// PORTS
//  clk           in   1        system clock (CLOCK_50 at top)
//  rst           in   1        asynchronous, active-high reset
//  req_valid     in   NREQ     per-requester byte valid
//  req_data      in   8*NREQ   per-requester byte; requester i uses bits [8*i+7:8*i]
//  req_last      in   NREQ     byte is the last of its packet
//  req_ready     out  NREQ     one-hot, one-cycle accept strobe; byte is consumed when valid & ready
//  tx_transmit   out  1        to uart .transmit; one-cycle pulse
//  tx_byte       out  8        to uart .tx_byte; held stable from the pulse until the byte completes
//  tx_busy       in   1        from uart .is_transmitting
//  grant_active  out  1        a requester currently owns the TX
//  grant_id      out  3        index of the owner (valid when grant_active = 1)
//  busy_to_err   out  1        one-cycle pulse: tx_busy did not rise within BUSY_TO cycles
// BEHAVIOUR
//  Reset values: req_ready=0, tx_transmit=0, tx_byte=0, grant_active=0, grant_id=0, busy_to_err=0, rr_ptr=0, state=IDLE.
//  States:
//   IDLE:  if any req_valid, choose the first asserted index searching from rr_ptr upward with wrap.
//          Set grant_id, grant_active=1, burst_cnt=0, go to LOAD. With no requests, remain in IDLE.
//   LOAD:  if req_valid[grant_id], pulse req_ready[grant_id] and tx_transmit, latch tx_byte and req_last.
//          Increment burst_cnt, clear to_cnt, go to WAIT_RISE.
//          If the owner has dropped valid, go to RELEASE (no stalling on an idle owner).
//   WAIT_RISE: wait for tx_busy=1, then go to WAIT_FALL.
//          Increment to_cnt each cycle; when to_cnt reaches BUSY_TO, pulse busy_to_err and go to RELEASE (byte treated as lost).
//   WAIT_FALL: on tx_busy=0, go to RELEASE if latched last=1 or burst_cnt==MAX_BURST, else go to LOAD.
//   RELEASE: grant_active=0, rr_ptr = grant_id+1, wrapping at NREQ; go to IDLE.
//  Latency: IDLE->pulse takes 2 cycles (IDLE, LOAD). One byte accepted per uart frame plus 2 cycles of overhead.
//  tx_transmit is never high in two consecutive cycles, and never high while in WAIT_RISE or WAIT_FALL.
//  A tx_busy already high in LOAD (left over from a previous frame) must not satisfy WAIT_RISE.
//   Qualify the rise with a registered previous value: require a 0->1 edge, or tx_busy=1 seen at least one cycle after the pulse.
//  Simultaneous requests: the lowest index at or above rr_ptr (with wrap) wins. Non-owners see req_ready=0 and must hold their data.
//  A requester that is the sole requester is re-granted immediately after RELEASE (rr_ptr wraps back to it).
//  burst_cnt width is 8 bits. Compare for equality with MAX_BURST; no overflow is possible.
//  Reset mid-frame: all state clears immediately. The uart's own reset is expected to abort the frame; no byte is replayed.
//  req_data and req_last are sampled only in LOAD. Changes in other states are ignored.
// STRUCTURE
//  Shared package uart_pkg: state encoding (IDLE, LOAD, WAIT_RISE, WAIT_FALL, RELEASE) and the BYTE_W=8 constant.
//  One sub-module, rr_pick: combinational round-robin picker.
//   Inputs: req_valid and rr_ptr. Outputs: onehot and idx. No other hierarchy.
// TESTING
//  Bench uses a uart model whose busy goes high 2 cycles after the pulse and stays high 20 cycles.
//  1 Single byte: req0 sends 0x41 with last=1 -> one tx_transmit pulse with tx_byte=0x41, one req_ready[0] pulse, grant released after busy falls.
//  2 Contention: req0 and req2 each send a 3-byte packet simultaneously, rr_ptr=0 -> bytes from req0 (3) then req2 (3), never interleaved; rr_ptr=3 at the end.
//  3 Burst cap: MAX_BURST=4, req1 sends 10 bytes with last only on byte 10, req3 also pending -> req1 sends 4, req3 is granted, then req1 resumes.
//  4 Busy timeout: model never raises busy -> busy_to_err pulses exactly BUSY_TO+1 cycles after tx_transmit; grant released; next request still served.
//  5 Reset mid-frame: assert rst during WAIT_FALL -> all outputs 0 in the same cycle; after release, a new byte 0x55 is sent normally.
//  6 Stale busy: tx_busy is held high when LOAD issues a pulse -> FSM waits for fresh busy and never issues a second pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit arbiter.
//   BYTE_W   : width of one uart byte
//   state_e  : arbiter FSM encoding
//   wrap_inc : increment a requester index, wrapping at n
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_RISE = 3'd2,
    WAIT_FALL = 3'd3,
    RELEASE   = 3'd4
  } state_e;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int unsigned n);
    if ({29'd0, v} + 32'd1 >= n) return 3'd0;
    return v + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_valid [NREQ-1:0] in  : request vector
//   rr_ptr    [2:0]      in  : first index to consider (must be < NREQ)
//   onehot    [NREQ-1:0] out : winner as a one-hot vector (all zero when idle)
//   idx       [2:0]      out : winner index (0 when idle)
// The winner is the first asserted request at or above rr_ptr, wrapping at NREQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [2:0]      rr_ptr,
  output logic [NREQ-1:0] onehot,
  output logic [2:0]      idx
);

  logic       found;
  logic [2:0] cand;

  // cand walks rr_ptr, rr_ptr+1, ... with wrap; the inner loop maps the
  // candidate index onto a constant bit select.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (cand == 3'(j)) && req_valid[j]) begin
          found     = 1'b1;
          idx       = cand;
          onehot[j] = 1'b1;
        end
      end
      cand = wrap_inc(cand, NREQ);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among NREQ requesters with round-robin
// arbitration and packet lock (owner keeps the TX until a byte flagged last
// or MAX_BURST bytes).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_data/req_last [per requester] in, req_ready out
//   tx_transmit, tx_byte out / tx_busy in : uart handshake
//   grant_active, grant_id : current owner
//   busy_to_err         : one-cycle pulse when tx_busy fails to rise in time
// Handshake: a requester holds req_valid/req_data/req_last stable until it
// sees req_ready; the byte is consumed in the cycle where valid & ready are
// both high. req_ready is a one-cycle strobe, only to the owner, only in LOAD,
// and coincides with the tx_transmit pulse.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int BUSY_TO   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   tx_transmit,
  output logic [BYTE_W-1:0]      tx_byte,
  input  logic                   tx_busy,
  output logic                   grant_active,
  output logic [2:0]             grant_id,
  output logic                   busy_to_err
);

  state_e             state_q, state_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic [7:0]         to_cnt_q, to_cnt_d;
  logic               last_q, last_d;
  logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
  logic               busy_prev_q, busy_prev_d;

  logic [NREQ-1:0]    pick_onehot;
  logic [2:0]         pick_idx;
  logic               owner_valid;
  logic               owner_last;
  logic [BYTE_W-1:0]  owner_data;
  logic               fire;
  logic               busy_rise;
  logic               to_expired;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .onehot    (pick_onehot),
    .idx       (pick_idx)
  );

  // Select the owner's request lines.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_id_q == 3'(j)) begin
        owner_valid = req_valid[j];
        owner_last  = req_last[j];
        owner_data  = req_data[BYTE_W*j +: BYTE_W];
      end
    end
  end

  assign fire       = (state_q == LOAD) && owner_valid;
  // Only a fresh 0->1 edge counts: a busy level left over from the previous
  // frame (or already high at the pulse) must not complete WAIT_RISE.
  assign busy_rise  = tx_busy && !busy_prev_q;
  assign to_expired = (to_cnt_q == 8'(BUSY_TO));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      to_cnt_q    <= '0;
      last_q      <= 1'b0;
      tx_byte_q   <= '0;
      busy_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      last_q      <= last_d;
      tx_byte_q   <= tx_byte_d;
      busy_prev_q <= busy_prev_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    to_cnt_d    = to_cnt_q;
    last_d      = last_q;
    tx_byte_d   = tx_byte_q;
    busy_prev_d = tx_busy;
    case (state_q)
      IDLE: begin
        if (|pick_onehot) begin
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (owner_valid) begin
          tx_byte_d   = owner_data;
          last_d      = owner_last;
          burst_cnt_d = burst_cnt_q + 8'd1;
          to_cnt_d    = '0;
          state_d     = WAIT_RISE;
        end else begin
          // Idle owner gives up the TX instead of stalling everyone else.
          state_d = RELEASE;
        end
      end
      WAIT_RISE: begin
        if (busy_rise) begin
          state_d = WAIT_FALL;
        end else if (to_expired) begin
          state_d = RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      WAIT_FALL: begin
        if (!tx_busy) begin
          state_d = (last_q || (burst_cnt_q == 8'(MAX_BURST))) ? RELEASE : LOAD;
        end
      end
      RELEASE: begin
        rr_ptr_d = wrap_inc(grant_id_q, NREQ);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (fire && (grant_id_q == 3'(j))) req_ready[j] = 1'b1;
    end
    tx_transmit  = fire;
    // Present the byte during the pulse itself, then hold the latched copy.
    tx_byte      = fire ? owner_data : tx_byte_q;
    grant_active = (state_q == LOAD) || (state_q == WAIT_RISE) || (state_q == WAIT_FALL);
    grant_id     = grant_id_q;
    busy_to_err  = (state_q == WAIT_RISE) && !busy_rise && to_expired;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int BUSY_TO   = 15;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_transmit;
  logic [7:0]        tx_byte;
  logic              tx_busy;
  logic              grant_active;
  logic [2:0]        grant_id;
  logic              busy_to_err;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .BUSY_TO(BUSY_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_transmit  (tx_transmit),
    .tx_byte      (tx_byte),
    .tx_busy      (tx_busy),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .busy_to_err  (busy_to_err)
  );

  // ---------------- uart model ----------------
  // mode 0: busy rises 2 cycles after the pulse and stays 20 cycles
  // mode 1: busy never rises
  // mode 2: busy driven directly by man_busy
  int   mode;
  logic man_busy;
  logic m_busy;
  logic m_dly;
  int   m_hold;

  assign tx_busy = (mode == 2) ? man_busy : m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_dly  <= 1'b0;
      m_hold <= 0;
    end else begin
      m_dly <= 1'b0;
      if (m_dly) begin
        m_busy <= 1'b1;
        m_hold <= 19;
      end else if (m_busy) begin
        if (m_hold == 0) m_busy <= 1'b0;
        else m_hold <= m_hold - 1;
      end
      if (tx_transmit && (mode == 0)) m_dly <= 1'b1;
    end
  end

  // ---------------- requester driver ----------------
  // Each entry is {last, data}.
  logic [8:0] q0[$], q1[$], q2[$], q3[$];
  logic [8:0] h0, h1, h2, h3, dummy;
  logic [NREQ-1:0] acc;

  task automatic update_drive();
    h0 = (q0.size() != 0) ? q0[0] : 9'h0;
    h1 = (q1.size() != 0) ? q1[0] : 9'h0;
    h2 = (q2.size() != 0) ? q2[0] : 9'h0;
    h3 = (q3.size() != 0) ? q3[0] : 9'h0;
    req_valid = {q3.size() != 0, q2.size() != 0, q1.size() != 0, q0.size() != 0};
    req_data  = {h3[7:0], h2[7:0], h1[7:0], h0[7:0]};
    req_last  = {h3[8], h2[8], h1[8], h0[8]};
  endtask

  task automatic push_byte(input int id, input logic [7:0] d, input logic l);
    case (id)
      0: q0.push_back({l, d});
      1: q1.push_back({l, d});
      2: q2.push_back({l, d});
      default: q3.push_back({l, d});
    endcase
    update_drive();
  endtask

  // A byte accepted in the previous cycle leaves its queue right after the edge.
  always @(posedge clk) begin
    #1;
    if (acc[0] && q0.size() != 0) dummy = q0.pop_front();
    if (acc[1] && q1.size() != 0) dummy = q1.pop_front();
    if (acc[2] && q2.size() != 0) dummy = q2.pop_front();
    if (acc[3] && q3.size() != 0) dummy = q3.pop_front();
    update_drive();
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [10:0] exp_q[$];   // {id[2:0], byte}
  logic [10:0] e_item;
  int   pulse_cnt, extra_cnt, viol_cnt, err_cnt;
  int   rdy_cnt[NREQ];
  logic prev_tx;
  logic [7:0] last_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d);
    exp_q.push_back({3'(id), d});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_byte = 8'h00;
      prev_tx   = 1'b0;
    end else begin
      if (tx_transmit) begin
        pulse_cnt++;
        if (prev_tx) viol_cnt++;
        if (!grant_active) viol_cnt++;
        if (exp_q.size() != 0) begin
          e_item = exp_q.pop_front();
          check("tx_pulse", 32'({req_ready, grant_id, tx_byte}),
                32'({4'(32'd1 << e_item[10:8]), e_item}));
        end else begin
          extra_cnt++;
        end
        last_byte = tx_byte;
      end else if (tx_byte != last_byte) begin
        viol_cnt++;
      end
      if (busy_to_err) err_cnt++;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) rdy_cnt[i]++;
      prev_tx = tx_transmit;
    end
    acc = req_valid & req_ready;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_transmit && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_transmit), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((grant_active || q0.size() != 0 || q1.size() != 0 || q2.size() != 0 ||
            q3.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    int n;
    checks = 0; errors = 0;
    pulse_cnt = 0; extra_cnt = 0; viol_cnt = 0; err_cnt = 0;
    for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
    prev_tx = 1'b0; last_byte = 8'h00; acc = '0;
    mode = 0; man_busy = 1'b0;
    rst = 1'b1;
    update_drive();

    // Reset values
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_transmit", 32'(tx_transmit), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy_to_err", 32'(busy_to_err), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("idle_no_grant", 32'(grant_active), 32'd0);

    // 1: single byte from req0
    tick();
    push_byte(0, 8'h41, 1'b1);
    expect_byte(0, 8'h41);
    @(negedge clk);
    check("t1_idle_cycle", 32'({grant_active, tx_transmit}), 32'd0);
    @(negedge clk);
    check("t1_pulse", 32'({grant_active, tx_transmit}), 32'b11);
    check("t1_byte", 32'(tx_byte), 32'h41);
    check("t1_ready", 32'(req_ready), 32'b0001);
    n = 0;
    while (grant_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t1_release_lat", 32'(n), 32'd23);
    check("t1_busy_low", 32'(tx_busy), 32'd0);
    check("t1_ready_cnt", 32'(rdy_cnt[0]), 32'd1);
    check("t1_pulse_cnt", 32'(pulse_cnt), 32'd1);

    // 2: contention req0 vs req2 from rr_ptr=0
    do_reset();
    tick();
    push_byte(0, 8'hA0, 1'b0); push_byte(0, 8'hA1, 1'b0); push_byte(0, 8'hA2, 1'b1);
    push_byte(2, 8'hC0, 1'b0); push_byte(2, 8'hC1, 1'b0); push_byte(2, 8'hC2, 1'b1);
    expect_byte(0, 8'hA0); expect_byte(0, 8'hA1); expect_byte(0, 8'hA2);
    expect_byte(2, 8'hC0); expect_byte(2, 8'hC1); expect_byte(2, 8'hC2);
    wait_idle("t2_done");
    @(negedge clk);
    check("t2_rr_ptr", 32'(dut.rr_ptr_q), 32'd3);

    // 3: burst cap with req3 waiting
    tick();
    for (int i = 0; i < 10; i++) push_byte(1, 8'(8'h10 + i), (i == 9));
    for (int i = 0; i < 4; i++) expect_byte(1, 8'(8'h10 + i));
    expect_byte(3, 8'hD0);
    for (int i = 4; i < 10; i++) expect_byte(1, 8'(8'h10 + i));
    wait_pulse("t3_first");
    tick();
    push_byte(3, 8'hD0, 1'b1);
    wait_idle("t3_done");
    check("t3_ready_req1", 32'(rdy_cnt[1]), 32'd10);
    check("t3_ready_req3", 32'(rdy_cnt[3]), 32'd1);

    // 4: busy never rises
    tick();
    mode = 1;
    push_byte(2, 8'h77, 1'b1);
    expect_byte(2, 8'h77);
    wait_pulse("t4_pulse");
    n = 0;
    while (!busy_to_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_to_latency", 32'(n), 32'(BUSY_TO + 1));
    check("t4_grant_at_err", 32'(grant_active), 32'd1);
    @(negedge clk);
    check("t4_err_one_cycle", 32'(busy_to_err), 32'd0);
    check("t4_released", 32'(grant_active), 32'd0);
    tick();
    mode = 0;
    push_byte(0, 8'h5A, 1'b1);
    expect_byte(0, 8'h5A);
    wait_idle("t4_next_served");

    // 5: reset during WAIT_FALL
    tick();
    push_byte(1, 8'h99, 1'b1);
    expect_byte(1, 8'h99);
    wait_pulse("t5_pulse");
    repeat (5) tick();
    check("t5_owned_before", 32'({grant_active, grant_id}), 32'b1001);
    rst = 1'b1;
    #1;
    check("t5_rst_grant", 32'(grant_active), 32'd0);
    check("t5_rst_grant_id", 32'(grant_id), 32'd0);
    check("t5_rst_tx_byte", 32'(tx_byte), 32'd0);
    check("t5_rst_others", 32'({req_ready, tx_transmit, busy_to_err}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    push_byte(0, 8'h55, 1'b1);
    expect_byte(0, 8'h55);
    wait_idle("t5_after_reset");

    // 6: stale busy at pulse time
    tick();
    mode = 2;
    man_busy = 1'b1;
    n = pulse_cnt;
    push_byte(2, 8'hC3, 1'b1);
    expect_byte(2, 8'hC3);
    wait_pulse("t6_pulse");
    repeat (5) tick();
    man_busy = 1'b0;
    @(negedge clk);
    check("t6_gap_owned", 32'(grant_active), 32'd1);
    tick();
    man_busy = 1'b1;
    @(negedge clk);
    check("t6_fresh_owned", 32'(grant_active), 32'd1);
    repeat (6) tick();
    man_busy = 1'b0;
    wait_idle("t6_done");
    check("t6_single_pulse", 32'(pulse_cnt - n), 32'd1);
    tick();
    mode = 0;

    // Totals
    repeat (3) tick();
    check("extra_pulses", 32'(extra_cnt), 32'd0);
    check("protocol_viol", 32'(viol_cnt), 32'd0);
    check("to_err_count", 32'(err_cnt), 32'd1);
    check("ready_req0", 32'(rdy_cnt[0]), 32'd6);
    check("ready_req1", 32'(rdy_cnt[1]), 32'd11);
    check("ready_req2", 32'(rdy_cnt[2]), 32'd5);
    check("ready_req3", 32'(rdy_cnt[3]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
